// File: rtl/regfile_wb_scoreboard.sv
// Hazard scoreboard and single write-port scheduler for the pipeline register file.
// Tracks busy destination registers, stalls RAW/WAW issue, round-robins ALU vs load writeback.
module regfile_wb_scoreboard #(
  parameter int REG_NUM_BITWIDTH = 5,
  parameter int WORD_BITWIDTH    = 32,
  parameter int CNT_BITWIDTH     = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] issue_rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] issue_rs2,
  input  logic [REG_NUM_BITWIDTH-1:0] issue_rd,
  input  logic                        issue_rd_we,
  output logic                        issue_stall,
  input  logic                        alu_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] alu_rd,
  input  logic [WORD_BITWIDTH-1:0]    alu_data,
  output logic                        alu_ready,
  input  logic                        ld_valid,
  input  logic [REG_NUM_BITWIDTH-1:0] ld_rd,
  input  logic [WORD_BITWIDTH-1:0]    ld_data,
  output logic                        ld_ready,
  output logic                        rf_we,
  output logic [REG_NUM_BITWIDTH-1:0] rf_waddr,
  output logic [WORD_BITWIDTH-1:0]    rf_wdata,
  output logic [CNT_BITWIDTH-1:0]     pending_cnt,
  output logic                        idle,
  output logic                        err_spurious
);

  localparam int NREGS = 2 ** REG_NUM_BITWIDTH;

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LD = 1'b1} grant_e;

  logic [NREGS-1:0]        busy_q, busy_d;
  grant_e                  last_grant_q, last_grant_d;
  logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic accept;
  logic set_chg;
  logic clr_chg;
  logic waddr_nz;

  // Handshake: a requester raises valid and holds rd/data until the cycle its
  // ready is high; ready is a single-cycle grant and the write commits at that edge.
  function automatic logic haz(input logic [NREGS-1:0] busy,
                               input logic [REG_NUM_BITWIDTH-1:0] r,
                               input logic we,
                               input logic [REG_NUM_BITWIDTH-1:0] waddr);
    // A register being written this cycle is bypassed by the register file.
    return (r != '0) && busy[r] && !(we && (waddr == r));
  endfunction

  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!rst) begin
      alu_ready = alu_valid && (!ld_valid || (last_grant_q == GRANT_LD));
      ld_ready  = ld_valid && (!alu_valid || (last_grant_q == GRANT_ALU));
    end
    rf_we    = alu_ready | ld_ready;
    rf_waddr = '0;
    rf_wdata = '0;
    if (alu_ready) begin
      rf_waddr = alu_rd;
      rf_wdata = alu_data;
    end else if (ld_ready) begin
      rf_waddr = ld_rd;
      rf_wdata = ld_data;
    end
  end

  always_comb begin
    issue_stall = 1'b0;
    if (!rst && issue_valid) begin
      issue_stall = haz(busy_q, issue_rs1, rf_we, rf_waddr) ||
                    haz(busy_q, issue_rs2, rf_we, rf_waddr) ||
                    (issue_rd_we && haz(busy_q, issue_rd, rf_we, rf_waddr));
    end
  end

  always_comb begin
    waddr_nz = rf_waddr != '0;
    accept   = !rst && issue_valid && !issue_stall && issue_rd_we && (issue_rd != '0);
    // Count only real bit transitions; a set on the register being cleared keeps it busy.
    set_chg  = accept && !busy_q[issue_rd];
    clr_chg  = rf_we && waddr_nz && busy_q[rf_waddr] && !(accept && (issue_rd == rf_waddr));

    busy_d = busy_q;
    if (rf_we && waddr_nz) busy_d[rf_waddr] = 1'b0;
    if (accept) busy_d[issue_rd] = 1'b1;

    cnt_d = cnt_q;
    if (set_chg && !clr_chg && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    else if (clr_chg && !set_chg && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;

    err_d = err_q || (rf_we && waddr_nz && !busy_q[rf_waddr]);

    last_grant_d = last_grant_q;
    if (alu_ready) last_grant_d = GRANT_ALU;
    else if (ld_ready) last_grant_d = GRANT_LD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      last_grant_q <= GRANT_ALU;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign pending_cnt  = cnt_q;
  assign err_spurious = err_q;
  assign idle         = (cnt_q == '0) && !alu_valid && !ld_valid;

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench for regfile_wb_scoreboard: hazards, round-robin writeback, clear/set races, reset.
module tb_regfile_wb_scoreboard;

  localparam int RN  = 5;
  localparam int WD  = 32;
  localparam int CNT = 6;

  logic          clk;
  logic          rst;
  logic          issue_valid;
  logic [RN-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          issue_rd_we;
  logic          issue_stall;
  logic          alu_valid;
  logic [RN-1:0] alu_rd;
  logic [WD-1:0] alu_data;
  logic          alu_ready;
  logic          ld_valid;
  logic [RN-1:0] ld_rd;
  logic [WD-1:0] ld_data;
  logic          ld_ready;
  logic          rf_we;
  logic [RN-1:0] rf_waddr;
  logic [WD-1:0] rf_wdata;
  logic [CNT-1:0] pending_cnt;
  logic          idle;
  logic          err_spurious;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WD-1:0] exp_q[$];

  regfile_wb_scoreboard #(
    .REG_NUM_BITWIDTH(RN), .WORD_BITWIDTH(WD), .CNT_BITWIDTH(CNT)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_cnt(pending_cnt), .idle(idle), .err_spurious(err_spurious)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_rd_we = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic drive_issue(input logic [RN-1:0] rs1, input logic [RN-1:0] rs2,
                             input logic [RN-1:0] rd, input logic we);
    issue_valid = 1'b1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd; issue_rd_we = we;
  endtask

  task automatic chk(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed sequence
  initial begin
    logic [WD-1:0] exp_w;
    int alu_idx;
    int ld_idx;
    clear_inputs();
    rst = 1'b1;
    drive_issue(5'd1, 5'd2, 5'd3, 1'b1);
    alu_valid = 1'b1; alu_rd = 5'd4;
    step(); settle();
    chk("rst_stall", {31'b0, issue_stall}, 0);
    chk("rst_alu_ready", {31'b0, alu_ready}, 0);
    chk("rst_rf_we", {31'b0, rf_we}, 0);
    chk("rst_cnt", {26'b0, pending_cnt}, 0);
    chk("rst_err", {31'b0, err_spurious}, 0);
    clear_inputs();
    step();
    rst = 1'b0;
    settle();
    chk("rst_idle", {31'b0, idle}, 1);

    // 1: RAW stall after issuing rd=5
    drive_issue(5'd0, 5'd0, 5'd5, 1'b1);
    settle();
    chk("t1_first_issue_nostall", {31'b0, issue_stall}, 0);
    step();
    drive_issue(5'd5, 5'd0, 5'd0, 1'b0);
    settle();
    chk("t1_raw_stall", {31'b0, issue_stall}, 1);
    chk("t1_cnt", {26'b0, pending_cnt}, 1);

    // 2: same-cycle writeback bypasses the hazard
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    settle();
    chk("t2_alu_ready", {31'b0, alu_ready}, 1);
    chk("t2_rf_we", {31'b0, rf_we}, 1);
    chk("t2_waddr", {27'b0, rf_waddr}, 5);
    chk("t2_wdata", rf_wdata, 32'hDEADBEEF);
    chk("t2_no_stall", {31'b0, issue_stall}, 0);
    step();
    clear_inputs();
    settle();
    chk("t2_cnt_after", {26'b0, pending_cnt}, 0);
    chk("t2_no_waddr", {27'b0, rf_waddr}, 0);
    drive_issue(5'd5, 5'd0, 5'd0, 1'b0);
    settle();
    chk("t2_busy5_clear", {31'b0, issue_stall}, 0);
    clear_inputs();

    // 3: tie after reset goes to the load requester first
    rst = 1'b1; step(); rst = 1'b0;
    drive_issue(5'd0, 5'd0, 5'd3, 1'b1); step();
    drive_issue(5'd0, 5'd0, 5'd7, 1'b1); step();
    clear_inputs();
    settle();
    chk("t3_cnt2", {26'b0, pending_cnt}, 2);
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_00A3;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_0017;
    settle();
    chk("t3_c1_ld_ready", {31'b0, ld_ready}, 1);
    chk("t3_c1_alu_ready", {31'b0, alu_ready}, 0);
    chk("t3_c1_waddr", {27'b0, rf_waddr}, 7);
    chk("t3_c1_wdata", rf_wdata, 32'h0000_0017);
    step();
    ld_valid = 1'b0;
    settle();
    chk("t3_c2_alu_ready", {31'b0, alu_ready}, 1);
    chk("t3_c2_waddr", {27'b0, rf_waddr}, 3);
    chk("t3_c2_cnt", {26'b0, pending_cnt}, 1);
    step();
    clear_inputs();
    settle();
    chk("t3_cnt0", {26'b0, pending_cnt}, 0);
    chk("t3_idle", {31'b0, idle}, 1);
    chk("t3_err", {31'b0, err_spurious}, 0);

    // 4: back-to-back ties alternate LD,ALU,... (last grant was ALU)
    exp_q.push_back(32'hB0); exp_q.push_back(32'hA0);
    exp_q.push_back(32'hB1); exp_q.push_back(32'hA1);
    exp_q.push_back(32'hB2); exp_q.push_back(32'hA2);
    alu_idx = 0;
    ld_idx = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hA0 + alu_idx;
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hB0 + ld_idx;
      settle();
      exp_w = exp_q.pop_front();
      chk($sformatf("t4_ld_ready_%0d", i), {31'b0, ld_ready}, ((i % 2) == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t4_wdata_%0d", i), rf_wdata, exp_w);
      if (ld_ready) ld_idx++;
      if (alu_ready) alu_idx++;
      step();
    end
    clear_inputs();
    settle();
    chk("t4_cnt", {26'b0, pending_cnt}, 0);
    chk("t4_err_rd0", {31'b0, err_spurious}, 0);

    // 5: clear and re-set of rd=9 in one cycle keeps it busy
    drive_issue(5'd0, 5'd0, 5'd9, 1'b1); step();
    clear_inputs();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    drive_issue(5'd0, 5'd0, 5'd9, 1'b1);
    settle();
    chk("t5_alu_ready", {31'b0, alu_ready}, 1);
    chk("t5_waw_bypass", {31'b0, issue_stall}, 0);
    step();
    clear_inputs();
    drive_issue(5'd9, 5'd0, 5'd0, 1'b0);
    settle();
    chk("t5_cnt", {26'b0, pending_cnt}, 1);
    chk("t5_still_busy", {31'b0, issue_stall}, 1);
    clear_inputs();
    alu_valid = 1'b1; alu_rd = 5'd9; step();
    clear_inputs();
    settle();
    chk("t5_cnt0", {26'b0, pending_cnt}, 0);

    // 6: spurious grant is sticky; reset drops everything
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC;
    settle();
    chk("t6_spur_granted", {31'b0, alu_ready}, 1);
    step();
    clear_inputs();
    settle();
    chk("t6_err_set", {31'b0, err_spurious}, 1);
    drive_issue(5'd0, 5'd0, 5'd4, 1'b1); step();
    clear_inputs();
    settle();
    chk("t6_err_sticky", {31'b0, err_spurious}, 1);
    chk("t6_cnt1", {26'b0, pending_cnt}, 1);
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    drive_issue(5'd4, 5'd0, 5'd0, 1'b0);
    rst = 1'b1;
    settle();
    chk("t6_rst_cnt", {26'b0, pending_cnt}, 0);
    chk("t6_rst_err", {31'b0, err_spurious}, 0);
    chk("t6_rst_alu_ready", {31'b0, alu_ready}, 0);
    chk("t6_rst_rf_we", {31'b0, rf_we}, 0);
    chk("t6_rst_stall", {31'b0, issue_stall}, 0);
    step();
    chk("t6_rst_hold_ready", {31'b0, alu_ready}, 0);
    rst = 1'b0;
    settle();
    chk("t6_post_rst_ready", {31'b0, alu_ready}, 1);
    chk("t6_post_rst_nostall", {31'b0, issue_stall}, 0);
    step();
    clear_inputs();
    settle();
    chk("t6_post_rst_spur", {31'b0, err_spurious}, 1);
    chk("t6_post_rst_cnt", {26'b0, pending_cnt}, 0);

    // Final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
